qdma_h2c_adapter: RTL and testbench



---
 rtl/qdma_h2c_adapter.sv | 174 +++++++++++++++++
 tb/tb_qdma_h2c_adapter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdma_h2c_adapter.sv
// QDMA H2C ingress adapter: mty->tkeep, drop of empty/bad
// packets, mid-packet error marking, 2-entry skid, counters.
module qdma_h2c_adapter #(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [DATA_WIDTH-1:0]    s_axis_qdma_h2c_tdata,
  input  logic                     s_axis_qdma_h2c_tvalid,
  output logic                     s_axis_qdma_h2c_tready,
  input  logic                     s_axis_qdma_h2c_tlast,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] s_axis_qdma_h2c_tuser_mty,
  input  logic                     s_axis_qdma_h2c_tuser_err,
  input  logic                     s_axis_qdma_h2c_tuser_zero_byte,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser_err,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int KW = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic                  err;
  } beat_t;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       err_flag;
  logic       rdy_en;
  logic [1:0] cnt;
  beat_t      ent0;
  beat_t      ent1;
  beat_t      wbeat;
  logic       acc;
  logic       bad;
  logic       wr;
  logic       drop_inc;
  logic       pop;

  assign bad = s_axis_qdma_h2c_tuser_zero_byte
             | s_axis_qdma_h2c_tuser_err;
  assign acc = s_axis_qdma_h2c_tvalid
             & s_axis_qdma_h2c_tready;
  assign pop = (cnt != 2'd0) & m_axis_tready;

  assign s_axis_qdma_h2c_tready =
    rdy_en & ((cnt != 2'd2) | (state == DROP));

  assign wbeat.data = s_axis_qdma_h2c_tdata;
  assign wbeat.keep = s_axis_qdma_h2c_tlast
    ? ({KW{1'b1}} >> s_axis_qdma_h2c_tuser_mty)
    : {KW{1'b1}};
  assign wbeat.last = s_axis_qdma_h2c_tlast;
  assign wbeat.err  = s_axis_qdma_h2c_tuser_err | err_flag;

  assign m_axis_tvalid    = (cnt != 2'd0);
  assign m_axis_tdata     = ent0.data;
  assign m_axis_tkeep     = ent0.keep;
  assign m_axis_tlast     = ent0.last;
  assign m_axis_tuser_err = ent0.err;

  // Input FSM state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= FIRST;
    else          state <= state_nxt;
  end

  // Input FSM next-state
  always_comb begin
    state_nxt = state;
    if (acc) begin
      unique case (state)
        FIRST: begin
          if (bad && !s_axis_qdma_h2c_tlast) state_nxt = DROP;
          else if (!bad && !s_axis_qdma_h2c_tlast) state_nxt = PASS;
          else state_nxt = FIRST;
        end
        PASS:    if (s_axis_qdma_h2c_tlast) state_nxt = FIRST;
        DROP:    if (s_axis_qdma_h2c_tlast) state_nxt = FIRST;
        default: state_nxt = FIRST;
      endcase
    end
  end

  // Input FSM outputs: buffer write and drop count strobe
  always_comb begin
    wr       = 1'b0;
    drop_inc = 1'b0;
    if (acc) begin
      unique case (state)
        FIRST: begin
          wr       = !bad;
          drop_inc = bad & s_axis_qdma_h2c_tlast;
        end
        PASS:    wr       = 1'b1;
        DROP:    drop_inc = s_axis_qdma_h2c_tlast;
        default: ;
      endcase
    end
  end

  // Sticky error across the rest of a forwarded packet
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_flag <= 1'b0;
    end else if (acc && state == PASS) begin
      if (s_axis_qdma_h2c_tlast) err_flag <= 1'b0;
      else err_flag <= err_flag | s_axis_qdma_h2c_tuser_err;
    end
  end

  // Hold tready low until the first edge after reset release
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // Two-entry skid buffer, head in ent0
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({wr, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= wbeat;
          else             ent1 <= wbeat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) ent0 <= ent1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= wbeat;
          end else begin
            ent0 <= ent1;
            ent1 <= wbeat;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop && ent0.last) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      if (drop_inc) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_qdma_h2c_adapter.sv
// Scoreboard bench for qdma_h2c_adapter.
// Driver queues expected beats; monitor pops on handshakes.
module tb_qdma_h2c_adapter;

  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          aresetn = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [5:0]    s_mty = '0;
  logic          s_err = 1'b0;
  logic          s_zb = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_terr;
  logic [31:0]   pkt_cnt;
  logic [31:0]   drop_cnt;

  qdma_h2c_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
    .clk                             (clk),
    .aresetn                         (aresetn),
    .s_axis_qdma_h2c_tdata           (s_tdata),
    .s_axis_qdma_h2c_tvalid          (s_tvalid),
    .s_axis_qdma_h2c_tready          (s_tready),
    .s_axis_qdma_h2c_tlast           (s_tlast),
    .s_axis_qdma_h2c_tuser_mty       (s_mty),
    .s_axis_qdma_h2c_tuser_err       (s_err),
    .s_axis_qdma_h2c_tuser_zero_byte (s_zb),
    .m_axis_tdata                    (m_tdata),
    .m_axis_tkeep                    (m_tkeep),
    .m_axis_tvalid                   (m_tvalid),
    .m_axis_tready                   (m_tready),
    .m_axis_tlast                    (m_tlast),
    .m_axis_tuser_err                (m_terr),
    .pkt_cnt                         (pkt_cnt),
    .drop_cnt                        (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          e;
  } exp_t;

  exp_t sbq[$];
  int   vec = 0;
  int   errs = 0;
  logic fwd = 1'b0;
  logic chk_rdy = 1'b0;
  logic tog_en = 1'b0;
  int   occ = 0;
  logic push_p = 1'b0;
  logic pop_p = 1'b0;
  logic [3:0] pat = 4'b1001;
  int   ti = 0;

  // monitor: scoreboard pop plus occupancy/ready checks
  always @(negedge clk) begin : mon
    exp_t x;
    if (chk_rdy) begin
      vec++;
      if (s_tready !== (occ < 2)) begin
        errs++;
        $display("FAIL occ_tready got=%b occ=%0d", s_tready, occ);
      end
      vec++;
      if (m_tvalid !== (occ != 0)) begin
        errs++;
        $display("FAIL occ_tvalid got=%b occ=%0d", m_tvalid, occ);
      end
    end
    push_p <= s_tvalid & s_tready & fwd;
    pop_p  <= m_tvalid & m_tready;
    if (m_tvalid && m_tready) begin
      vec++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_beat d=%h", m_tdata[31:0]);
      end else begin
        x = sbq.pop_front();
        if ({m_tdata, m_tkeep, m_tlast, m_terr} !== x) begin
          errs++;
          $display("FAIL beat got d=%h k=%h l=%b e=%b want d=%h k=%h l=%b e=%b",
                   m_tdata[31:0], m_tkeep, m_tlast, m_terr,
                   x.d[31:0], x.k, x.l, x.e);
        end
      end
    end
  end

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) occ <= 0;
    else occ <= occ + int'(push_p) - int'(pop_p);
  end

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      m_tready = pat[ti[1:0]];
      ti++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [DW-1:0] pd(input logic [31:0] t);
    return {16{t}};
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l,
                      input logic [5:0] mty, input logic e,
                      input logic zb, input logic f,
                      input logic [KW-1:0] ek, input logic ee,
                      input logic must_rdy);
    int   n;
    bit   ok;
    exp_t x;
    n  = 0;
    ok = 0;
    s_tdata = d; s_tlast = l; s_mty = mty;
    s_err = e; s_zb = zb; fwd = f; s_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (must_rdy && n == 0) chk("drop_tready", 64'(s_tready), 64'd1);
      if (s_tready) begin
        ok = 1;
        if (f) begin
          x.d = d; x.k = ek; x.l = l; x.e = ee;
          sbq.push_back(x);
        end
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vec++;
      errs++;
      $display("FAIL send_timeout d=%h", d[31:0]);
    end
    s_tvalid = 1'b0;
    fwd = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout got=%0d want=0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [KW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #2 aresetn = 1'b0;
    #20;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_tkeep", m_tkeep, 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    chk("tready_pre", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    chk("tready_up", 64'(s_tready), 64'd1);
    m_tready = 1'b1;

    // two-beat packet, mty=44 on last
    send(pd(32'h1111_0001), 0, 6'd0, 0, 0, 1, ONES, 0, 0);
    chk("lat_valid", 64'(m_tvalid), 64'd1);
    chk("lat_data", 64'(m_tdata[31:0]), 64'h1111_0001);
    send(pd(32'h1111_0002), 1, 6'd44, 0, 0, 1,
         64'h0000_0000_000F_FFFF, 0, 0);
    drain();
    chk("t1_pkt", 64'(pkt_cnt), 64'd1);

    // errored first beat: whole packet dropped
    send(pd(32'h2222_0001), 0, 6'd0, 1, 0, 0, ONES, 0, 0);
    send(pd(32'h2222_0002), 0, 6'd0, 0, 0, 0, ONES, 0, 1);
    send(pd(32'h2222_0003), 1, 6'd0, 0, 0, 0, ONES, 0, 1);
    @(posedge clk); #1;
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    send(pd(32'h2222_0004), 1, 6'd59, 0, 0, 1, 64'h1F, 0, 0);
    drain();
    chk("t2_pkt", 64'(pkt_cnt), 64'd2);

    // zero-byte single beat
    send(pd(32'h3333_0001), 1, 6'd0, 0, 1, 0, ONES, 0, 0);
    drain();
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_pkt", 64'(pkt_cnt), 64'd2);

    // mid-packet error marks beats 2 and 3
    send(pd(32'h4444_0001), 0, 6'd0, 0, 0, 1, ONES, 0, 0);
    send(pd(32'h4444_0002), 0, 6'd0, 1, 0, 1, ONES, 1, 0);
    send(pd(32'h4444_0003), 1, 6'd0, 0, 0, 1, ONES, 1, 0);
    drain();
    chk("t4_pkt", 64'(pkt_cnt), 64'd3);
    chk("t4_drop", 64'(drop_cnt), 64'd2);

    // back-to-back single beats with toggling backpressure
    chk_rdy = 1'b1;
    tog_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(pd(32'h5500_0000 + 32'(i)), 1, 6'(i), 0, 0, 1,
           ONES >> i, 0, 0);
    end
    tog_en = 1'b0;
    @(posedge clk); #2;
    m_tready = 1'b1;
    drain();
    chk_rdy = 1'b0;
    chk("t5_pkt", 64'(pkt_cnt), 64'd13);

    // reset in the middle of a 3-beat packet
    send(pd(32'h6666_0001), 0, 6'd0, 0, 0, 1, ONES, 0, 0);
    send(pd(32'h6666_0002), 0, 6'd0, 0, 0, 1, ONES, 0, 0);
    aresetn = 1'b0;
    sbq.delete();
    #1;
    chk("mrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mrst_tkeep", m_tkeep, 64'd0);
    chk("mrst_pkt", 64'(pkt_cnt), 64'd0);
    chk("mrst_drop", 64'(drop_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    send(pd(32'h7777_0001), 1, 6'd8, 0, 0, 1,
         64'h00FF_FFFF_FFFF_FFFF, 0, 0);
    drain();
    chk("t6_pkt", 64'(pkt_cnt), 64'd1);
    chk("t6_drop", 64'(drop_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
